// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmit FSM states, oversampling and
// frame constants, and the parity helper used by both directions.
package uart_pkg;

    typedef enum logic [1:0] {
        PD_NONE  = 2'b00,
        PD_EVEN  = 2'b01,
        PD_ODD   = 2'b10,
        PD_NONE9 = 2'b11
    } pdsel_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } tx_state_t;

    localparam int unsigned SAMPLES_HI = 4;
    localparam int unsigned SAMPLES_LO = 16;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned BAUD_W     = $clog2(SAMPLES_LO);
    localparam int unsigned BITCNT_W   = $clog2(DATA_BITS);

    // Even mode makes the total count of ones even; odd mode makes it odd.
    function automatic logic parity_bit(input pdsel_t mode, input logic [DATA_BITS-1:0] data);
        return (mode == PD_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: counts oversample ticks within one bit period and flags the
// tick that closes the bit.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    input  logic brgh,
    output logic bit_end
);

    logic [BAUD_W-1:0] count;
    logic [BAUD_W-1:0] last;

    always_comb begin
        last = brgh ? BAUD_W'(SAMPLES_HI - 1) : BAUD_W'(SAMPLES_LO - 1);
    end

    assign bit_end = tick && (count == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= bit_end ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: one-byte holding register feeding a shift register that
// serialises start, 8 data bits LSB first, optional parity and 1-2 stop bits.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter bit CTS_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic       brg_sample_i,
    input  logic       brgh_i,
    input  logic [1:0] pdsel_i,
    input  logic       stsel_i,
    input  logic       thr_push_i,
    input  logic [7:0] tx_byte_i,
    input  logic       cts_i,
    output logic       thr_empty_o,
    output logic       trmt_o,
    output logic       txd_o
);

    tx_state_t               state;
    logic [DATA_BITS-1:0]    thr;
    logic [DATA_BITS-1:0]    tsr;
    logic [DATA_BITS-1:0]    data_copy;
    logic                    thr_valid;
    logic [BITCNT_W-1:0]     bit_cnt;
    logic                    brgh_q;
    pdsel_t                  pdsel_q;
    logic                    stsel_q;
    logic                    txd;

    logic tick;
    logic bit_end;
    logic start_ok;
    logic frame_end;
    logic load;
    logic abort;

    assign tick      = brg_sample_i & enable_i;
    assign start_ok  = enable_i & thr_valid & ~(CTS_EN & cts_i);
    assign frame_end = bit_end & (((state == STOP1) & ~stsel_q) | (state == STOP2));
    // Start is polled on every sample pulse while idle, and at the closing
    // boundary of a frame so queued bytes follow with no idle gap.
    assign load      = start_ok & (((state == IDLE) & brg_sample_i) | frame_end);
    assign abort     = ~enable_i & (state != IDLE);

    uart_bit_timer u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   ((state == IDLE) | ~enable_i),
        .tick    (tick),
        .brgh    (brgh_q),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            thr       <= '0;
            tsr       <= '0;
            data_copy <= '0;
            thr_valid <= 1'b0;
            bit_cnt   <= '0;
            brgh_q    <= 1'b0;
            pdsel_q   <= PD_NONE;
            stsel_q   <= 1'b0;
            txd       <= 1'b1;
        end else if (abort) begin
            state     <= IDLE;
            thr_valid <= 1'b0;
            txd       <= 1'b1;
        end else begin
            if (load) begin
                thr_valid <= 1'b0;
            end else if (thr_push_i && !thr_valid) begin
                thr       <= tx_byte_i;
                thr_valid <= 1'b1;
            end

            if (load) begin
                tsr       <= thr;
                data_copy <= thr;
                brgh_q    <= brgh_i;
                pdsel_q   <= pdsel_t'(pdsel_i);
                stsel_q   <= stsel_i;
                state     <= START;
                txd       <= 1'b0;
            end else if (bit_end) begin
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_cnt <= BITCNT_W'(DATA_BITS - 1);
                        txd     <= tsr[0];
                    end
                    DATA: begin
                        tsr <= tsr >> 1;
                        if (bit_cnt == '0) begin
                            if (pdsel_q == PD_EVEN || pdsel_q == PD_ODD) begin
                                state <= PARITY;
                                txd   <= parity_bit(pdsel_q, data_copy);
                            end else begin
                                state <= STOP1;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            txd     <= tsr[1];
                        end
                    end
                    PARITY: begin
                        state <= STOP1;
                        txd   <= 1'b1;
                    end
                    STOP1: begin
                        state <= stsel_q ? STOP2 : IDLE;
                        txd   <= 1'b1;
                    end
                    STOP2: begin
                        state <= IDLE;
                        txd   <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        txd   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign thr_empty_o = ~thr_valid;
    assign trmt_o      = (state == IDLE);
    assign txd_o       = txd;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frames are captured one entry per BRG
// pulse and compared against hand-built bit patterns.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       brg;
    logic       brgh;
    logic [1:0] pdsel;
    logic       stsel;
    logic       push;
    logic [7:0] tx_byte;
    logic       cts;
    logic       thr_empty;
    logic       trmt;
    logic       txd;

    int total = 0;
    int bad   = 0;
    int brg_div = 0;

    logic cap_txd[$];
    logic cap_trmt[$];

    typedef struct {
        logic        brgh;
        logic [1:0]  pdsel;
        logic        stsel;
        logic [7:0]  data;
        int          nbits;
        logic [23:0] frame;
    } vec_t;

    vec_t vecs[7];

    uart_transmitter #(.CTS_EN(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .brg_sample_i (brg),
        .brgh_i       (brgh),
        .pdsel_i      (pdsel),
        .stsel_i      (stsel),
        .thr_push_i   (push),
        .tx_byte_i    (tx_byte),
        .cts_i        (cts),
        .thr_empty_o  (thr_empty),
        .trmt_o       (trmt),
        .txd_o        (txd)
    );

    always #5 clk = ~clk;

    // One-clk BRG pulse every third clock.
    initial begin
        brg = 1'b0;
        forever begin
            @(negedge clk);
            brg_div = (brg_div == 2) ? 0 : brg_div + 1;
            brg = (brg_div == 0);
        end
    end

    always @(posedge clk) begin
        if (brg) begin
            #1;
            cap_txd.push_back(txd);
            cap_trmt.push_back(trmt);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=no finish required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got=timeout required=event", name);
    endtask

    task automatic clear_capture();
        cap_txd.delete();
        cap_trmt.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        tx_byte = b;
        push    = 1'b1;
        @(negedge clk);
        push    = 1'b0;
    endtask

    task automatic wait_pulses(input int n);
        int seen = 0;
        while (seen < n) begin
            @(posedge clk);
            if (brg) seen++;
        end
        @(negedge clk);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (trmt !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (trmt !== 1'b0) timeout_fail({name, " start"});
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        wait_start(name);
        while (trmt !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (trmt !== 1'b1) timeout_fail({name, " end"});
        @(negedge clk);
    endtask

    task automatic check_frame(input string name, input logic [23:0] exp, input int nbits, input int per);
        int first = -1;
        int last  = -1;
        int len   = 0;
        int unstable = 0;
        logic [23:0] got = '0;
        for (int i = 0; i < cap_trmt.size(); i++) begin
            if (cap_trmt[i] === 1'b0) begin
                if (first < 0) first = i;
                last = i;
                len++;
            end
        end
        check({name, " length"}, len, nbits * per);
        check({name, " gap"}, last - first + 1, len);
        if (len == nbits * per && first >= 0) begin
            for (int b = 0; b < nbits; b++) begin
                got[b] = cap_txd[first + b * per];
                for (int k = 1; k < per; k++) begin
                    if (cap_txd[first + b * per + k] !== got[b]) unstable++;
                end
            end
        end
        check({name, " bits"}, 32'(got), 32'(exp));
        check({name, " stable"}, unstable, 0);
    endtask

    initial begin
        // frame bit i = i-th bit on the line: {stop(s), parity, data, start}
        vecs[0] = '{1'b1, 2'b00, 1'b0, 8'h55, 10, 24'({1'b1, 8'h55, 1'b0})};
        vecs[1] = '{1'b0, 2'b01, 1'b0, 8'hA5, 11, 24'({1'b1, 1'b0, 8'hA5, 1'b0})};
        vecs[2] = '{1'b0, 2'b10, 1'b1, 8'hA5, 12, 24'({2'b11, 1'b1, 8'hA5, 1'b0})};
        vecs[3] = '{1'b1, 2'b11, 1'b1, 8'h3C, 11, 24'({2'b11, 8'h3C, 1'b0})};
        vecs[4] = '{1'b1, 2'b01, 1'b0, 8'h07, 11, 24'({1'b1, 1'b1, 8'h07, 1'b0})};
        vecs[5] = '{1'b1, 2'b10, 1'b0, 8'h00, 11, 24'({1'b1, 1'b1, 8'h00, 1'b0})};
        vecs[6] = '{1'b0, 2'b00, 1'b1, 8'hFF, 11, 24'({2'b11, 8'hFF, 1'b0})};

        rst_n   = 1'b0;
        enable  = 1'b1;
        brgh    = 1'b1;
        pdsel   = 2'b00;
        stsel   = 1'b0;
        push    = 1'b0;
        tx_byte = 8'h00;
        cts     = 1'b0;

        repeat (3) @(negedge clk);
        check("reset txd", 32'(txd), 1);
        check("reset trmt", 32'(trmt), 1);
        check("reset thr_empty", 32'(thr_empty), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            brgh  = vecs[i].brgh;
            pdsel = vecs[i].pdsel;
            stsel = vecs[i].stsel;
            clear_capture();
            push_byte(vecs[i].data);
            check($sformatf("vec%0d thr full", i), 32'(thr_empty), 0);
            wait_frame($sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].nbits, vecs[i].brgh ? 4 : 16);
            check($sformatf("vec%0d idle txd", i), 32'(txd), 1);
        end

        // Back-to-back frames; a push while the THR is full is dropped.
        brgh = 1'b1; pdsel = 2'b00; stsel = 1'b0;
        clear_capture();
        push_byte(8'h12);
        begin
            int n = 0;
            while (thr_empty !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (thr_empty !== 1'b1) timeout_fail("b2b thr release");
        end
        push_byte(8'h34);
        check("b2b thr full", 32'(thr_empty), 0);
        push_byte(8'h99);
        wait_frame("b2b");
        check_frame("b2b", 24'({1'b1, 8'h34, 1'b0, 1'b1, 8'h12, 1'b0}), 20, 4);
        wait_pulses(30);
        check("b2b drop trmt", 32'(trmt), 1);
        check("b2b drop thr_empty", 32'(thr_empty), 1);

        // CTS holds off the frame; mid-frame CTS is ignored.
        cts = 1'b1;
        push_byte(8'h80);
        wait_pulses(40);
        check("cts hold trmt", 32'(trmt), 1);
        check("cts hold txd", 32'(txd), 1);
        check("cts hold thr_empty", 32'(thr_empty), 0);
        clear_capture();
        cts = 1'b0;
        wait_start("cts");
        wait_pulses(8);
        cts = 1'b1;
        wait_frame("cts");
        check_frame("cts", 24'({1'b1, 8'h80, 1'b0}), 10, 4);
        check("cts first pulse starts", 32'(cap_trmt[0]), 0);
        cts = 1'b0;

        // Abort during data bit 3; a push in the abort clk is discarded.
        clear_capture();
        push_byte(8'hFF);
        wait_start("abort");
        wait_pulses(17);
        check("abort pre trmt", 32'(trmt), 0);
        enable  = 1'b0;
        push    = 1'b1;
        tx_byte = 8'h11;
        @(posedge clk);
        #1;
        check("abort txd", 32'(txd), 1);
        check("abort trmt", 32'(trmt), 1);
        check("abort thr_empty", 32'(thr_empty), 1);
        @(negedge clk);
        push = 1'b0;
        wait_pulses(5);
        check("disabled trmt", 32'(trmt), 1);
        push_byte(8'hC3);
        check("disabled push accepted", 32'(thr_empty), 0);
        wait_pulses(8);
        check("disabled no start", 32'(trmt), 1);
        clear_capture();
        enable = 1'b1;
        wait_frame("reenable");
        check_frame("reenable", 24'({1'b1, 8'hC3, 1'b0}), 10, 4);

        // Asynchronous reset mid-frame.
        brgh = 1'b0;
        push_byte(8'h00);
        wait_start("areset");
        push_byte(8'hAA);
        wait_pulses(19);
        check("areset pre txd", 32'(txd), 0);
        check("areset pre thr_empty", 32'(thr_empty), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset txd", 32'(txd), 1);
        check("areset trmt", 32'(trmt), 1);
        check("areset thr_empty", 32'(thr_empty), 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_pulses(20);
        check("areset stays idle", 32'(trmt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
UART transmit path, the counterpart of the UART receive path. It has a 1-byte transmit holding register (THR) and a transmit shift register (TSR), and serialises frames onto txd_o: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits. Bit timing comes from the shared baud-rate generator pulse brg_sample_i. CTS flow control is honoured at frame boundaries.

Parameters:
CTS_EN, 1, 1 = cts_i gates frame start; 0 = cts_i ignored.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
enable_i  input  1  transmitter enable; deassert aborts the current frame and flushes the THR
brg_sample_i  input  1  one-clk oversample pulse from the BRG
brgh_i  input  1  1 = 4 samples/bit, 0 = 16 samples/bit
pdsel_i  input  2  00 none, 01 even parity, 10 odd parity, 11 none
stsel_i  input  1  0 = 1 stop bit, 1 = 2 stop bits
thr_push_i  input  1  write tx_byte_i into the THR
tx_byte_i  input  8  byte to transmit
cts_i  input  1  peer not-ready when high (matches the peer's rts = rx-full)
thr_empty_o  output  1  THR can accept a byte
trmt_o  output  1  TSR empty and line idle
txd_o  output  1  serial line, idle high

Behaviour:
- Reset values: txd_o=1, thr_empty_o=1, trmt_o=1. Internally: state IDLE, THR invalid, baud and bit counters 0.
- THR handshake:
  - thr_push_i while thr_empty_o=1 -> tx_byte_i is captured; thr_empty_o=0 on the next clk.
  - thr_push_i while thr_empty_o=0 -> ignored, no side effect.
  - thr_push_i while enable_i=0 -> still accepted.
- Bit period N = 4 (brgh_i=1) or 16 (brgh_i=0) brg_sample_i pulses. The baud counter increments only on brg_sample_i & enable_i. A bit boundary is the brg_sample_i pulse with count = N-1; the counter then wraps to 0.
- Frame start, evaluated on each brg_sample_i in IDLE: start when enable_i & THR valid & !(CTS_EN & cts_i).
  - Then: TSR<=THR; THR invalidated (thr_empty_o=1 next clk); brgh_i/pdsel_i/stsel_i latched for the whole frame; baud counter cleared; state START.
  - txd_o is registered and goes 0 one clk after the start pulse.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2. Each transition occurs on a bit boundary.
  - START -> DATA. The bit counter loads 7.
  - DATA: txd_o=TSR[0]; TSR shifts right at each bit boundary. The counter decrements; at 0, go to PARITY if latched pdsel is 01/10, else STOP1.
  - PARITY: txd_o = ^data for 01, ~^data for 10. data is the byte as loaded, held in a separate copy register.
  - STOP1: txd_o=1. Go to STOP2 if latched stsel=1, else frame end.
  - STOP2: txd_o=1, then frame end.
  - Frame end: if the start condition holds, go directly to START with no idle gap (back-to-back). Otherwise go to IDLE.
- trmt_o=1 only when the state is IDLE; it is 0 from the frame-start clk until the end of the last stop bit.
- cts_i is sampled only at frame start. A change mid-frame does not affect the current frame.
- enable_i=0 mid-frame: on the next clk, state=IDLE, txd_o=1, THR flushed (thr_empty_o=1), baud counter frozen and cleared. A push in the same clk as the abort is discarded.
- Mode inputs changing mid-frame take effect from the next frame only.
- Asynchronous reset at any point returns all outputs to their reset values; a partial frame is not completed.

Decomposition:
- Package uart_pkg:
  - pdsel encodings (PD_NONE=00, PD_EVEN=01, PD_ODD=10, PD_NONE9=11)
  - tx state typedef
  - SAMPLES_HI=4, SAMPLES_LO=16
  - DATA_BITS=8
- One natural sub-module: uart_bit_timer. It holds the baud counter plus bit-boundary/sample-point decode and is reusable by the receiver. Everything else stays in uart_transmitter.

Test Plan:
- brgh=1, pdsel=00, stsel=0, push 0x55, cts=0 -> txd_o = 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each held exactly 4 brg pulses; trmt_o returns to 1 after 40 pulses.
- brgh=0, pdsel=01, push 0xA5 -> parity bit 0; repeat with pdsel=10 -> parity bit 1; each bit held 16 pulses; stsel=1 gives a 32-pulse high stop.
- Push 0x12 then 0x34 as soon as thr_empty_o=1 -> the second start bit immediately follows the first stop bit (no idle gap); a third push while thr_empty_o=0 is dropped.
- CTS_EN=1, cts_i=1, push 0x80 -> txd_o stays 1 and trmt_o stays 1. Drop cts_i -> the frame starts on the next brg_sample_i. Raise cts_i mid-frame -> the frame completes.
- Deassert enable_i during data bit 3 of 0xFF -> next clk txd_o=1, trmt_o=1, thr_empty_o=1; re-enable with a new push -> clean frame.
- Loopback txd_o into uart_receiver with matching brgh/pdsel, random bytes across all pdsel modes -> received byte equals sent byte, ferr=perr=0.
